uart_rx: RTL and testbench

- UART receiver, the counterpart of the project's uart_tx on the serial console link.
- Oversamples uart_rxd with a fixed CYCLES_PER_BIT clock divider and samples each bit at mid-bit.
- Deserialises PAYLOAD_BITS LSB-first and presents each byte with a one-cycle valid strobe to the CPU-side UART register block.
- Flags framing errors; tolerates glitches on the start bit.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings used by uart_rx and uart_tx,
// plus the default bit period in clock cycles.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    RECV      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_state_t;

  localparam int DEFAULT_CYCLES_PER_BIT = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial input; resets to the
// idle-high line level so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, LSB-first deserialisation, framing-error
// strobe. Define UART_RX_PARITY_EN to add a parity bit check (PARITY_ODD).
module uart_rx
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BITS   = 8,
  parameter int STOP_BITS      = 1,
  parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_busy,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_ferr,
  output logic                    uart_rx_perr
);

  localparam int CW = 1 + $clog2(CYCLES_PER_BIT);
  localparam logic [CW-1:0] HALF_BIT  = CW'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT  = CW'(CYCLES_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  uart_state_t             state;
  logic [CW-1:0]           cycle_cnt;
  logic [3:0]              bit_cnt;
  logic [PAYLOAD_BITS-1:0] sr;
  logic                    rxs;

`ifdef UART_RX_PARITY_EN
  logic par_err;
  logic perr_q;
  assign uart_rx_perr = perr_q;
`else
  assign uart_rx_perr = 1'b0;
`endif

  uart_rx_sync u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (uart_rxd),
    .q      (rxs)
  );

  // Stop bits are sampled mid-bit, so returning to IDLE there leaves half a
  // bit of margin to catch a back-to-back start edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      cycle_cnt     <= '0;
      bit_cnt       <= '0;
      sr            <= '0;
      uart_rx_data  <= '0;
      uart_rx_valid <= 1'b0;
      uart_rx_ferr  <= 1'b0;
      uart_rx_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err       <= 1'b0;
      perr_q        <= 1'b0;
`endif
    end else begin
      uart_rx_valid <= 1'b0;
      uart_rx_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q        <= 1'b0;
`endif
      cycle_cnt <= (state == IDLE) ? '0 : cycle_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (!rxs && uart_rx_en) begin
            state        <= START;
            uart_rx_busy <= 1'b1;
            bit_cnt      <= '0;
          end
        end

        START: begin
          if (cycle_cnt == HALF_BIT) begin
            cycle_cnt <= '0;
            if (rxs) begin
              state        <= IDLE;
              uart_rx_busy <= 1'b0;
            end else begin
              state <= RECV;
            end
          end
        end

        RECV: begin
          if (cycle_cnt == FULL_BIT) begin
            cycle_cnt               <= '0;
            sr[PAYLOAD_BITS-1]      <= rxs;
            for (int i = 0; i < PAYLOAD_BITS - 1; i++) sr[i] <= sr[i+1];
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cycle_cnt == FULL_BIT) begin
            cycle_cnt <= '0;
            par_err   <= rxs ^ (^sr) ^ PARITY_ODD;
            state     <= STOP;
          end
        end
`endif

        STOP: begin
          if (cycle_cnt == FULL_BIT) begin
            cycle_cnt <= '0;
            if (!rxs) begin
              state        <= WAIT_HIGH;
              uart_rx_ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_q       <= par_err;
`endif
            end else if (bit_cnt == LAST_STOP) begin
              state         <= IDLE;
              uart_rx_busy  <= 1'b0;
              uart_rx_data  <= sr;
              uart_rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_q        <= par_err;
`endif
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

        // A held-low line (break) reports one framing error, then waits here.
        WAIT_HIGH: begin
          if (rxs) begin
            state        <= IDLE;
            uart_rx_busy <= 1'b0;
            cycle_cnt    <= '0;
          end
        end

        default: begin
          state        <= IDLE;
          uart_rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected results, a
// negedge monitor pops and compares on every valid/ferr strobe.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_CYCLES = 11 * CPB;
  localparam int LATENCY      = 170;
`else
  localparam int FRAME_CYCLES = 10 * CPB;
  localparam int LATENCY      = 154;
`endif

  logic       clk        = 1'b0;
  logic       resetn     = 1'b0;
  logic       uart_rxd   = 1'b1;
  logic       uart_rx_en = 1'b0;
  logic       uart_rx_busy;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_ferr;
  logic       uart_rx_perr;

  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
    bit         perr;
  } exp_t;

  exp_t sb[$];
  int   valid_cycles[$];
  int   checks      = 0;
  int   errors      = 0;
  int   cycle       = 0;
  int   ferr_count  = 0;
  int   start_cycle = 0;
`ifdef UART_RX_PARITY_EN
  bit   flip_parity = 1'b0;
`endif

  uart_rx #(
    .PAYLOAD_BITS   (8),
    .STOP_BITS      (1),
    .CYCLES_PER_BIT (CPB)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .uart_rxd      (uart_rxd),
    .uart_rx_en    (uart_rx_en),
    .uart_rx_busy  (uart_rx_busy),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_ferr  (uart_rx_ferr),
    .uart_rx_perr  (uart_rx_perr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic pushExpect(input bit is_ferr, input logic [7:0] data, input bit perr);
    exp_t e;
    e.is_ferr = is_ferr;
    e.data    = data;
    e.perr    = perr;
    sb.push_back(e);
  endtask

  // Drives one frame starting at a negedge; the line is left at the stop level.
  task automatic applyStimulus(input logic [7:0] d, input bit stop_high, input int stop_hold);
    uart_rxd    = 1'b0;
    start_cycle = cycle;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd = (^d) ^ flip_parity;
    repeat (CPB) @(negedge clk);
`endif
    uart_rxd = stop_high;
    repeat (stop_hold) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (uart_rx_valid || uart_rx_ferr) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_strobe valid=%0b ferr=%0b data=%0h",
                 uart_rx_valid, uart_rx_ferr, uart_rx_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("strobe_valid", 32'(uart_rx_valid), 32'(!e.is_ferr));
        checkOutput("strobe_ferr",  32'(uart_rx_ferr),  32'(e.is_ferr));
        checkOutput("strobe_data",  32'(uart_rx_data),  32'(e.data));
        checkOutput("strobe_perr",  32'(uart_rx_perr),  32'(e.perr));
      end
      if (uart_rx_valid) valid_cycles.push_back(cycle);
      if (uart_rx_ferr) ferr_count++;
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int busy_cycles;
    int f0;

    repeat (4) @(negedge clk);
    checkOutput("rst_busy",  32'(uart_rx_busy),  32'd0);
    checkOutput("rst_valid", 32'(uart_rx_valid), 32'd0);
    checkOutput("rst_data",  32'(uart_rx_data),  32'd0);
    checkOutput("rst_ferr",  32'(uart_rx_ferr),  32'd0);
    checkOutput("rst_perr",  32'(uart_rx_perr),  32'd0);
    resetn     = 1'b1;
    uart_rx_en = 1'b1;
    repeat (4) @(negedge clk);

    // Single 0x55; latency counted from the first clk edge that sees the low line.
    pushExpect(1'b0, 8'h55, 1'b0);
    applyStimulus(8'h55, 1'b1, CPB);
    checkOutput("count_55", 32'(valid_cycles.size()), 32'd1);
    lat = (valid_cycles.size() > 0) ? valid_cycles[$] - (start_cycle + 1) : -1;
    checkOutput("latency_55", 32'(lat), 32'(LATENCY));

    // Back-to-back frames.
    pushExpect(1'b0, 8'hA3, 1'b0);
    pushExpect(1'b0, 8'h0F, 1'b0);
    applyStimulus(8'hA3, 1'b1, CPB);
    applyStimulus(8'h0F, 1'b1, CPB);
    repeat (4) @(negedge clk);
    checkOutput("b2b_count", 32'(valid_cycles.size()), 32'd3);
    lat = (valid_cycles.size() >= 3) ? valid_cycles[2] - valid_cycles[1] : -1;
    checkOutput("b2b_spacing", 32'(lat), 32'(FRAME_CYCLES));

    // Five-cycle glitch: busy for exactly the half-bit start check.
    repeat (CPB) @(negedge clk);
    busy_cycles = 0;
    uart_rxd    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) uart_rxd = 1'b1;
      @(negedge clk);
      busy_cycles += int'(uart_rx_busy);
    end
    checkOutput("glitch_busy_cycles", 32'(busy_cycles), 32'd8);
    checkOutput("glitch_no_valid", 32'(valid_cycles.size()), 32'd3);
    checkOutput("glitch_no_ferr", 32'(ferr_count), 32'd0);

    // Stop bit low followed by a long break: exactly one ferr, data held.
    f0 = ferr_count;
    pushExpect(1'b1, 8'h0F, 1'b0);
    applyStimulus(8'h81, 1'b0, 400);
    checkOutput("break_busy", 32'(uart_rx_busy), 32'd1);
    checkOutput("break_ferr_count", 32'(ferr_count - f0), 32'd1);
    uart_rxd = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("break_idle", 32'(uart_rx_busy), 32'd0);
    checkOutput("break_data_held", 32'(uart_rx_data), 32'h0F);
    repeat (CPB) @(negedge clk);

    // Reset in the middle of the data bits, then a clean 0x3C.
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checkOutput("recv_busy", 32'(uart_rx_busy), 32'd1);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_busy", 32'(uart_rx_busy), 32'd0);
    checkOutput("midrst_data", 32'(uart_rx_data), 32'd0);
    checkOutput("midrst_valid", 32'(uart_rx_valid), 32'd0);
    resetn = 1'b1;
    repeat (CPB) @(negedge clk);
    pushExpect(1'b0, 8'h3C, 1'b0);
    applyStimulus(8'h3C, 1'b1, CPB);
    checkOutput("post_rst_count", 32'(valid_cycles.size()), 32'd4);

    // Enable dropped mid-frame still completes; the following frame is ignored.
    pushExpect(1'b0, 8'h5A, 1'b0);
    fork
      applyStimulus(8'h5A, 1'b1, CPB);
      begin
        repeat (20) @(negedge clk);
        uart_rx_en = 1'b0;
      end
    join
    checkOutput("en_drop_count", 32'(valid_cycles.size()), 32'd5);
    applyStimulus(8'hC3, 1'b1, CPB);
    repeat (4) @(negedge clk);
    checkOutput("en_off_count", 32'(valid_cycles.size()), 32'd5);
    checkOutput("en_off_busy", 32'(uart_rx_busy), 32'd0);
    uart_rx_en = 1'b1;
    repeat (4) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so even parity expects a 1 on the line.
    flip_parity = 1'b1;
    pushExpect(1'b0, 8'h07, 1'b1);
    applyStimulus(8'h07, 1'b1, CPB);
    flip_parity = 1'b0;
    pushExpect(1'b0, 8'h07, 1'b0);
    applyStimulus(8'h07, 1'b1, CPB);
    repeat (4) @(negedge clk);
    checkOutput("parity_count", 32'(valid_cycles.size()), 32'd7);
`endif

    repeat (20) @(negedge clk);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
